// File: rtl/rs_cmd_conditioner_pkg.sv
// Shared state encoding and resolution rule for the R-S latch command conditioner.
// The state code doubles as the {r_out, s_out} output pair.
package rs_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_SET  = 2'b01,
    ST_RST  = 2'b10
  } state_e;

  localparam int DEF_DB_CYCLES   = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // Maps a debounced {r,s} pair to a latch command; S=R=1 never leaves as 11.
  function automatic state_e resolve(input logic s, input logic r, input logic rDominant);
    state_e res;
    case ({r, s})
      2'b01:   res = ST_SET;
      2'b10:   res = ST_RST;
      2'b11:   res = rDominant ? ST_RST : ST_HOLD;
      default: res = ST_HOLD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rs_cmd_conditioner_debounce_chan.sv
// One switch channel: multi-flop synchroniser followed by a persistence debouncer.
// A new level is accepted only after it has differed from the stable level for DB_CYCLES cycles.
module debounce_chan
  import rs_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   w_synced;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Any cycle of agreement restarts the count, so short bounces never reach CNT_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (w_synced == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_stable <= w_synced;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign stable = r_stable;

endmodule

// File: rtl/rs_cmd_conditioner.sv
// Conditions raw S/R switches into clean latch levels, entry strobes and a conflict flag.
// Outputs are all registered so the latch never sees a combinational glitch.
module rs_cmd_conditioner
  import rs_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int R_DOMINANT  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_s_raw,
  input  logic sw_r_raw,
  output logic s_out,
  output logic r_out,
  output logic set_pls,
  output logic rst_pls,
  output logic conflict
);

  localparam logic R_DOM = (R_DOMINANT != 0);

  logic   w_stableS;
  logic   w_stableR;
  state_e r_state;
  state_e w_nextState;
  logic   w_setPlsNext;
  logic   w_rstPlsNext;
  logic   r_setPls;
  logic   r_rstPls;
  logic   r_conflict;
  logic [1:0] w_stateBits;

  debounce_chan #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES)
  ) u_db_s (
    .clk   (clk),
    .rst   (rst),
    .raw   (sw_s_raw),
    .stable(w_stableS)
  );

  debounce_chan #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES)
  ) u_db_r (
    .clk   (clk),
    .rst   (rst),
    .raw   (sw_r_raw),
    .stable(w_stableR)
  );

  // Strobes are computed from the transition so they land in the same cycle as the new state.
  always_comb begin
    w_nextState  = r_state;
    w_setPlsNext = 1'b0;
    w_rstPlsNext = 1'b0;
    w_nextState  = resolve(w_stableS, w_stableR, R_DOM);
    w_setPlsNext = (w_nextState == ST_SET) && (r_state != ST_SET);
    w_rstPlsNext = (w_nextState == ST_RST) && (r_state != ST_RST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HOLD;
      r_setPls   <= 1'b0;
      r_rstPls   <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_setPls   <= w_setPlsNext;
      r_rstPls   <= w_rstPlsNext;
      r_conflict <= w_stableS & w_stableR;
    end
  end

  assign w_stateBits = r_state;
  assign s_out       = w_stateBits[0];
  assign r_out       = w_stateBits[1];
  assign set_pls     = r_setPls;
  assign rst_pls     = r_rstPls;
  assign conflict    = r_conflict;

endmodule

// File: tb/tb_rs_cmd_conditioner.sv
// Bench for rs_cmd_conditioner: directed scenarios plus randomized switch activity against a
// window-based reference model, on an R-dominant and a hold-on-conflict instance side by side.
module tb_rs_cmd_conditioner;

  localparam int SYNC = 2;
  localparam int DB   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic swS = 1'b0;
  logic swR = 1'b0;

  logic sOut1, rOut1, setP1, rstP1, conf1;
  logic sOut0, rOut0, setP0, rstP0, conf0;
  logic [4:0] obs1, obs0;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  rs_cmd_conditioner #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB), .R_DOMINANT(1)) dut (
    .clk(clk), .rst(rst), .sw_s_raw(swS), .sw_r_raw(swR),
    .s_out(sOut1), .r_out(rOut1), .set_pls(setP1), .rst_pls(rstP1), .conflict(conf1)
  );

  rs_cmd_conditioner #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB), .R_DOMINANT(0)) dutHold (
    .clk(clk), .rst(rst), .sw_s_raw(swS), .sw_r_raw(swR),
    .s_out(sOut0), .r_out(rOut0), .set_pls(setP0), .rst_pls(rstP0), .conflict(conf0)
  );

  // Observation vectors ordered {s_out, r_out, set_pls, rst_pls, conflict}.
  assign obs1 = {sOut1, rOut1, setP1, rstP1, conf1};
  assign obs0 = {sOut0, rOut0, setP0, rstP0, conf0};

  // Reference model: raw delayed SYNC samples, stable flips once the last DB synced samples all
  // disagree with it, command follows the previous cycle's stable pair.
  bit mSyncS[SYNC];
  bit mSyncR[SYNC];
  bit histS[$];
  bit histR[$];
  bit mStS, mStR, mConf;
  logic [1:0] mCmd1, mCmd0;
  bit mSet1, mRst1, mSet0, mRst0;

  function automatic logic [1:0] modelCmd(bit s, bit r, bit rDom);
    if (s && !r) return 2'b01;
    if (r && !s) return 2'b10;
    if (s && r && rDom) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit allDiffer(bit h[$], bit st);
    foreach (h[i]) if (h[i] == st) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [4:0] modelObs(logic [1:0] cmd, bit setP, bit rstP, bit conf);
    return {cmd[0], cmd[1], setP, rstP, conf};
  endfunction

  always @(posedge clk) begin : modelBlk
    logic [1:0] n1, n0;
    if (rst === 1'b1) begin
      foreach (mSyncS[k]) begin mSyncS[k] = 1'b0; mSyncR[k] = 1'b0; end
      histS.delete(); histR.delete();
      for (int k = 0; k < DB; k++) begin histS.push_back(1'b0); histR.push_back(1'b0); end
      mStS = 0; mStR = 0; mConf = 0;
      mCmd1 = 2'b00; mCmd0 = 2'b00;
      mSet1 = 0; mRst1 = 0; mSet0 = 0; mRst0 = 0;
    end else begin
      n1 = modelCmd(mStS, mStR, 1'b1);
      n0 = modelCmd(mStS, mStR, 1'b0);
      mSet1 = (n1 == 2'b01) && (mCmd1 != 2'b01);
      mRst1 = (n1 == 2'b10) && (mCmd1 != 2'b10);
      mSet0 = (n0 == 2'b01) && (mCmd0 != 2'b01);
      mRst0 = (n0 == 2'b10) && (mCmd0 != 2'b10);
      mCmd1 = n1;
      mCmd0 = n0;
      mConf = mStS & mStR;
      if (allDiffer(histS, mStS)) mStS = !mStS;
      if (allDiffer(histR, mStR)) mStR = !mStR;
      for (int k = SYNC - 1; k > 0; k--) begin
        mSyncS[k] = mSyncS[k-1];
        mSyncR[k] = mSyncR[k-1];
      end
      mSyncS[0] = (swS === 1'b1);
      mSyncR[0] = (swR === 1'b1);
      void'(histS.pop_front()); histS.push_back(mSyncS[SYNC-1]);
      void'(histR.pop_front()); histR.push_back(mSyncR[SYNC-1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; swS = 1'bx; swR = 1'bx;
    tick();
    tick();
    swS = 1'b0; swR = 1'b0;
    tick();
    nCompared++;
    if (obs1 !== 5'b00000) begin
      nMismatched++;
      $display("[TB] FAIL reset_rdom: got %b want 00000", obs1);
    end
    nCompared++;
    if (obs0 !== 5'b00000) begin
      nMismatched++;
      $display("[TB] FAIL reset_hold: got %b want 00000", obs0);
    end
    rst = 1'b0;
    tick();
    nCompared++;
    if (obs1 !== 5'b00000) begin
      nMismatched++;
      $display("[TB] FAIL reset_release: got %b want 00000", obs1);
    end
  endtask

  task automatic test_set_latency();
    swS = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      logic [4:0] want;
      tick();
      want = (e < 7) ? 5'b00000 : (e == 7) ? 5'b10100 : 5'b10000;
      nCompared++;
      if (obs1 !== want) begin
        nMismatched++;
        $display("[TB] FAIL set_latency edge %0d: got %b want %b", e, obs1, want);
      end
    end
    swS = 1'b0;
    repeat (10) tick();
    nCompared++;
    if (obs1 !== 5'b00000) begin
      nMismatched++;
      $display("[TB] FAIL set_release: got %b want 00000", obs1);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pattern;
    pattern = 4'b1010;
    for (int i = 3; i >= 0; i--) begin
      swS = pattern[i];
      tick();
      nCompared++;
      if (obs1 !== 5'b00000) begin
        nMismatched++;
        $display("[TB] FAIL bounce_quiet step %0d: got %b want 00000", 3 - i, obs1);
      end
    end
    swS = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      logic [4:0] want;
      tick();
      want = (e < 7) ? 5'b00000 : 5'b10100;
      nCompared++;
      if (obs1 !== want) begin
        nMismatched++;
        $display("[TB] FAIL bounce_settle edge %0d: got %b want %b", e, obs1, want);
      end
    end
    swS = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_conflict();
    swS = 1'b1; swR = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      logic [4:0] want1, want0;
      tick();
      want1 = (e < 7) ? 5'b00000 : (e == 7) ? 5'b01011 : 5'b01001;
      want0 = (e < 7) ? 5'b00000 : 5'b00001;
      nCompared++;
      if (obs1 !== want1) begin
        nMismatched++;
        $display("[TB] FAIL conflict_rdom edge %0d: got %b want %b", e, obs1, want1);
      end
      nCompared++;
      if (obs0 !== want0) begin
        nMismatched++;
        $display("[TB] FAIL conflict_hold edge %0d: got %b want %b", e, obs0, want0);
      end
    end
    swR = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      logic [4:0] want1, want0;
      tick();
      want1 = (e < 7) ? 5'b01001 : 5'b10100;
      want0 = (e < 7) ? 5'b00001 : 5'b10100;
      nCompared++;
      if (obs1 !== want1) begin
        nMismatched++;
        $display("[TB] FAIL conflict_exit_rdom edge %0d: got %b want %b", e, obs1, want1);
      end
      nCompared++;
      if (obs0 !== want0) begin
        nMismatched++;
        $display("[TB] FAIL conflict_exit_hold edge %0d: got %b want %b", e, obs0, want0);
      end
    end
    swS = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    swS = 1'b1;
    repeat (8) tick();
    swS = 1'b0; swR = 1'b1;
    repeat (4) tick();
    nCompared++;
    if (obs1 !== 5'b10000) begin
      nMismatched++;
      $display("[TB] FAIL mid_pre_reset: got %b want 10000", obs1);
    end
    rst = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      tick();
      nCompared++;
      if (obs1 !== 5'b00000 || obs0 !== 5'b00000) begin
        nMismatched++;
        $display("[TB] FAIL mid_in_reset edge %0d: got %b/%b want 00000", e, obs1, obs0);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      logic [4:0] want;
      tick();
      want = (e < 7) ? 5'b00000 : 5'b01010;
      nCompared++;
      if (obs1 !== want || obs0 !== want) begin
        nMismatched++;
        $display("[TB] FAIL mid_release edge %0d: got %b/%b want %b", e, obs1, obs0, want);
      end
    end
    swR = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_random();
    int holdS = 0;
    int holdR = 0;
    logic prevSet1 = 1'b0, prevRst1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic [4:0] want1, want0;
      if (holdS == 0) begin swS = 1'($urandom_range(0, 1)); holdS = $urandom_range(1, 9); end
      else holdS--;
      if (holdR == 0) begin swR = 1'($urandom_range(0, 1)); holdR = $urandom_range(1, 9); end
      else holdR--;
      rst = ($urandom_range(0, 79) == 0);
      tick();
      want1 = modelObs(mCmd1, mSet1, mRst1, mConf);
      want0 = modelObs(mCmd0, mSet0, mRst0, mConf);
      nCompared++;
      if (obs1 !== want1) begin
        nMismatched++;
        $display("[TB] FAIL random_rdom cycle %0d: got %b want %b", c, obs1, want1);
      end
      nCompared++;
      if (obs0 !== want0) begin
        nMismatched++;
        $display("[TB] FAIL random_hold cycle %0d: got %b want %b", c, obs0, want0);
      end
      nCompared++;
      if ((sOut1 & rOut1) || (sOut0 & rOut0)) begin
        nMismatched++;
        $display("[TB] FAIL both_high cycle %0d: got %b%b/%b%b want never 11", c, sOut1, rOut1,
                 sOut0, rOut0);
      end
      nCompared++;
      if ((setP1 && prevSet1) || (rstP1 && prevRst1)) begin
        nMismatched++;
        $display("[TB] FAIL strobe_width cycle %0d: got set %b rst %b twice want 1-cycle", c,
                 setP1, rstP1);
      end
      prevSet1 = setP1;
      prevRst1 = rstP1;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_set_latency();
    test_bounce();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
